// File: rtl/ipu_host_seq.sv
`default_nettype none
// ============================================================================
// Module   : ipu_host_seq
// Purpose  : Host-side sequencer for the IPU. Buffers register-file rows and
//            instruction words written by the host, then on start resets the
//            IPU, streams rows and instructions into the IPU load ports, times
//            the run and collects every WT_RD readback into a result buffer.
//            A sticky flag records any IPU overflow seen while running.
// Ports    :
//   clk, hs_rst_n                 clock / async active-low reset
//   hs_wr_en/sel/adrs/data        host buffer write port (IDLE only)
//   hs_inst_cnt, hs_start         run length (clamped to MAX_INST) and start
//   hs_rd_adrs/rd_data/rd_vld     combinational result buffer read port
//   hs_busy, hs_done              run status / one-cycle completion pulse
//   hs_of_flag, hs_ret_cnt        sticky overflow, readbacks captured
//   ipu_rst, ipu_rf_*, ipu_im_*   registered IPU load interface
//   ipu_OF, ipu_TB_ret, ipu_ret_adrs  IPU overflow and readback inputs
// Revision : 1.0 - initial release
// ============================================================================
module ipu_host_seq #(
  parameter int DATA_W   = 16,
  parameter int INST_W   = 26,
  parameter int ADR_W    = 4,
  parameter int MAX_INST = 16,
  parameter int RET_LAT  = 7,
  localparam int CNT_W   = $clog2(MAX_INST + 1)
) (
  input  logic              clk,
  input  logic              hs_rst_n,
  // host buffer write port
  input  logic              hs_wr_en,
  input  logic              hs_wr_sel,
  input  logic [ADR_W-1:0]  hs_wr_adrs,
  input  logic [INST_W-1:0] hs_wr_data,
  // run control
  input  logic [CNT_W-1:0]  hs_inst_cnt,
  input  logic              hs_start,
  // result read port
  input  logic [ADR_W-1:0]  hs_rd_adrs,
  output logic [DATA_W-1:0] hs_rd_data,
  output logic              hs_rd_vld,
  // status
  output logic              hs_busy,
  output logic              hs_done,
  output logic              hs_of_flag,
  output logic [CNT_W-1:0]  hs_ret_cnt,
  // IPU load interface
  output logic              ipu_rst,
  output logic              ipu_rf_ld_en,
  output logic [DATA_W-1:0] ipu_rf_load,
  output logic [ADR_W-1:0]  ipu_rf_ld_adrs,
  output logic              ipu_im_ld_en,
  output logic [INST_W-1:0] ipu_im_instLoad,
  // IPU readback interface
  input  logic              ipu_OF,
  input  logic [DATA_W-1:0] ipu_TB_ret,
  input  logic [ADR_W-1:0]  ipu_ret_adrs
);

  localparam int         ROWS     = 1 << ADR_W;
  localparam int         IIDX_W   = $clog2(MAX_INST);
  localparam int         RUN_W    = $clog2(RET_LAT + MAX_INST + 1);
  localparam logic [1:0] OP_WT_RD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_IRST  = 3'd1,
    S_LD_RF = 3'd2,
    S_LD_IM = 3'd3,
    S_RUN   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // Storage without reset: host buffers and result data survive reset; only
  // the result-valid flags carry meaning across runs.
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] row_q  [ROWS];
  logic [INST_W-1:0] inst_q [MAX_INST];
  logic [DATA_W-1:0] res_q  [ROWS];

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    idx_q, idx_d;          // LD_RF row / LD_IM instruction index
  logic [RUN_W-1:0]    run_q, run_d;          // RUN cycle counter
  logic [CNT_W-1:0]    cnt_q, cnt_d;          // latched instruction count
  logic [MAX_INST-1:0] rd_sh_q, rd_sh_d;      // per-instruction WT_RD bits
  logic [ROWS-1:0]     vld_q, vld_d;
  logic [CNT_W-1:0]    ret_cnt_q, ret_cnt_d;
  logic                of_q, of_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ipu_rst_q, ipu_rst_d;
  logic                rf_ld_en_q, rf_ld_en_d;
  logic [DATA_W-1:0]   rf_load_q, rf_load_d;
  logic [ADR_W-1:0]    rf_ld_adrs_q, rf_ld_adrs_d;
  logic                im_ld_en_q, im_ld_en_d;
  logic [INST_W-1:0]   im_inst_q, im_inst_d;

  logic [CNT_W-1:0]    w_cnt_clamp;
  logic [CNT_W-1:0]    w_idx_nxt;
  logic [RUN_W-1:0]    w_run_last;
  logic                w_in_ret;
  logic                w_cap;
  logic                w_host_wr;

  function automatic logic is_rd(input logic [INST_W-1:0] iw);
    return iw[INST_W-1 -: 2] == OP_WT_RD;
  endfunction

  assign w_cnt_clamp = (hs_inst_cnt > CNT_W'(MAX_INST)) ? CNT_W'(MAX_INST) : hs_inst_cnt;
  assign w_idx_nxt   = idx_q + CNT_W'(1);
  assign w_run_last  = RUN_W'(RET_LAT) + RUN_W'(cnt_q) - RUN_W'(1);

  // Readback window: run cycle RET_LAT+k returns instruction k. The WT_RD bits
  // are shifted right once per window cycle, so bit 0 always belongs to the
  // instruction whose result is on the bus right now.
  assign w_in_ret  = (state_q == S_RUN) && (run_q >= RUN_W'(RET_LAT));
  assign w_cap     = w_in_ret && rd_sh_q[0];
  assign w_host_wr = hs_wr_en && (state_q == S_IDLE);

  // --------------------------------------------------------------------------
  // Host buffer writes
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_host_wr) begin
      if (hs_wr_sel) begin
        inst_q[hs_wr_adrs[IIDX_W-1:0]] <= hs_wr_data;
      end else begin
        row_q[hs_wr_adrs] <= hs_wr_data[DATA_W-1:0];
      end
    end
  end

  // Readback data is sampled only in capture cycles, so a floating bus at
  // any other time never reaches the buffer.
  always_ff @(posedge clk) begin
    if (w_cap) begin
      res_q[ipu_ret_adrs] <= ipu_TB_ret;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. All IPU-facing outputs are computed for the state being
  // entered, so the registered copies line up with the state register.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    run_d        = run_q;
    cnt_d        = cnt_q;
    rd_sh_d      = rd_sh_q;
    vld_d        = vld_q;
    ret_cnt_d    = ret_cnt_q;
    of_d         = of_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    ipu_rst_d    = 1'b0;
    rf_ld_en_d   = 1'b0;
    rf_load_d    = '0;
    rf_ld_adrs_d = '0;
    im_ld_en_d   = 1'b0;
    im_inst_d    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (hs_start) begin
          state_d   = S_IRST;
          ipu_rst_d = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = w_cnt_clamp;
          vld_d     = '0;
          ret_cnt_d = '0;
          of_d      = 1'b0;
          rd_sh_d   = '0;
        end
      end

      S_IRST: begin
        state_d      = S_LD_RF;
        idx_d        = '0;
        rf_ld_en_d   = 1'b1;
        rf_ld_adrs_d = '0;
        rf_load_d    = row_q[0];
      end

      S_LD_RF: begin
        if (idx_q == CNT_W'(ROWS - 1)) begin
          idx_d = '0;
          if (cnt_q == '0) begin
            // Nothing to execute: skip instruction load and RUN entirely.
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d    = S_LD_IM;
            im_ld_en_d = 1'b1;
            im_inst_d  = inst_q[0];
            rd_sh_d[0] = is_rd(inst_q[0]);
          end
        end else begin
          idx_d        = w_idx_nxt;
          rf_ld_en_d   = 1'b1;
          rf_ld_adrs_d = w_idx_nxt[ADR_W-1:0];
          rf_load_d    = row_q[w_idx_nxt[ADR_W-1:0]];
        end
      end

      S_LD_IM: begin
        if (idx_q == cnt_q - CNT_W'(1)) begin
          state_d = S_RUN;
          run_d   = '0;
        end else begin
          idx_d                           = w_idx_nxt;
          im_ld_en_d                      = 1'b1;
          im_inst_d                       = inst_q[w_idx_nxt[IIDX_W-1:0]];
          rd_sh_d[w_idx_nxt[IIDX_W-1:0]]  = is_rd(inst_q[w_idx_nxt[IIDX_W-1:0]]);
        end
      end

      S_RUN: begin
        of_d = of_q | ipu_OF;
        if (w_cap) begin
          vld_d[ipu_ret_adrs] = 1'b1;
          ret_cnt_d           = ret_cnt_q + CNT_W'(1);
        end
        if (w_in_ret) begin
          rd_sh_d = rd_sh_q >> 1;
        end
        if (run_q == w_run_last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          run_d = run_q + RUN_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers. Reset aborts any run at once and holds the
  // IPU in reset with all load enables low.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge hs_rst_n) begin
    if (!hs_rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      run_q        <= '0;
      cnt_q        <= '0;
      rd_sh_q      <= '0;
      vld_q        <= '0;
      ret_cnt_q    <= '0;
      of_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ipu_rst_q    <= 1'b1;
      rf_ld_en_q   <= 1'b0;
      rf_load_q    <= '0;
      rf_ld_adrs_q <= '0;
      im_ld_en_q   <= 1'b0;
      im_inst_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      run_q        <= run_d;
      cnt_q        <= cnt_d;
      rd_sh_q      <= rd_sh_d;
      vld_q        <= vld_d;
      ret_cnt_q    <= ret_cnt_d;
      of_q         <= of_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ipu_rst_q    <= ipu_rst_d;
      rf_ld_en_q   <= rf_ld_en_d;
      rf_load_q    <= rf_load_d;
      rf_ld_adrs_q <= rf_ld_adrs_d;
      im_ld_en_q   <= im_ld_en_d;
      im_inst_q    <= im_inst_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign hs_rd_data      = res_q[hs_rd_adrs];
  assign hs_rd_vld       = vld_q[hs_rd_adrs];
  assign hs_busy         = busy_q;
  assign hs_done         = done_q;
  assign hs_of_flag      = of_q;
  assign hs_ret_cnt      = ret_cnt_q;
  assign ipu_rst         = ipu_rst_q;
  assign ipu_rf_ld_en    = rf_ld_en_q;
  assign ipu_rf_load     = rf_load_q;
  assign ipu_rf_ld_adrs  = rf_ld_adrs_q;
  assign ipu_im_ld_en    = im_ld_en_q;
  assign ipu_im_instLoad = im_inst_q;

endmodule
`default_nettype wire

// File: tb/tb_ipu_host_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ipu_host_seq
// Purpose  : Self-checking bench for ipu_host_seq. Stimulus pushes expected
//            load beats and completion records into queues; a monitor pops
//            and compares whenever the DUT presents them. A small IPU stand-in
//            returns readbacks in the slots chosen by each test.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ipu_host_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        hs_rst_n = 1'b0;
  logic        hs_wr_en = 1'b0;
  logic        hs_wr_sel = 1'b0;
  logic [3:0]  hs_wr_adrs = '0;
  logic [25:0] hs_wr_data = '0;
  logic [4:0]  hs_inst_cnt = '0;
  logic        hs_start = 1'b0;
  logic [3:0]  hs_rd_adrs = '0;
  logic [15:0] hs_rd_data;
  logic        hs_rd_vld;
  logic        hs_busy;
  logic        hs_done;
  logic        hs_of_flag;
  logic [4:0]  hs_ret_cnt;
  logic        ipu_rst;
  logic        ipu_rf_ld_en;
  logic [15:0] ipu_rf_load;
  logic [3:0]  ipu_rf_ld_adrs;
  logic        ipu_im_ld_en;
  logic [25:0] ipu_im_instLoad;
  logic        ipu_OF = 1'b0;
  logic [15:0] ipu_TB_ret = 16'hF00D;
  logic [3:0]  ipu_ret_adrs = 4'd3;

  ipu_host_seq dut (
    .clk             (clk),
    .hs_rst_n        (hs_rst_n),
    .hs_wr_en        (hs_wr_en),
    .hs_wr_sel       (hs_wr_sel),
    .hs_wr_adrs      (hs_wr_adrs),
    .hs_wr_data      (hs_wr_data),
    .hs_inst_cnt     (hs_inst_cnt),
    .hs_start        (hs_start),
    .hs_rd_adrs      (hs_rd_adrs),
    .hs_rd_data      (hs_rd_data),
    .hs_rd_vld       (hs_rd_vld),
    .hs_busy         (hs_busy),
    .hs_done         (hs_done),
    .hs_of_flag      (hs_of_flag),
    .hs_ret_cnt      (hs_ret_cnt),
    .ipu_rst         (ipu_rst),
    .ipu_rf_ld_en    (ipu_rf_ld_en),
    .ipu_rf_load     (ipu_rf_load),
    .ipu_rf_ld_adrs  (ipu_rf_ld_adrs),
    .ipu_im_ld_en    (ipu_im_ld_en),
    .ipu_im_instLoad (ipu_im_instLoad),
    .ipu_OF          (ipu_OF),
    .ipu_TB_ret      (ipu_TB_ret),
    .ipu_ret_adrs    (ipu_ret_adrs)
  );

  int n_chk = 0;
  int n_err = 0;
  int gcyc = 0;
  int start_cyc = 0;
  int done_pulses = 0;
  bit mon_on = 1'b0;
  bit drv_on = 1'b0;
  int n_run = 0;
  int of_c = -1;

  bit          plan_rd   [16];
  logic [15:0] plan_data [16];
  logic [3:0]  plan_adrs [16];
  logic [15:0] row_m     [16];
  logic [25:0] inst_m    [16];

  logic [19:0] q_rf[$];
  logic [25:0] q_im[$];
  int          q_irst[$];
  int          q_dc[$];
  int          q_drc[$];
  int          q_dof[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) gcyc <= gcyc + 1;
  always @(negedge clk) if (hs_done) done_pulses <= done_pulses + 1;

  // IPU stand-in: readback slot k of an n-instruction run sits at
  // c = 24 + n + k (1 IRST + 16 LD_RF + n LD_IM + RET_LAT). Outside the window
  // the bus carries junk that must never be stored.
  always @(posedge clk) begin
    int c;
    int k;
    #2;
    ipu_OF       = 1'b0;
    ipu_TB_ret   = 16'hF00D;
    ipu_ret_adrs = 4'd3;
    if (drv_on) begin
      c = gcyc - start_cyc;
      if (c >= 24 + n_run && c < 24 + 2 * n_run) begin
        k = c - 24 - n_run;
        if (plan_rd[k]) begin
          ipu_TB_ret   = plan_data[k];
          ipu_ret_adrs = plan_adrs[k];
        end else begin
          ipu_TB_ret   = 16'hDEAD;
          ipu_ret_adrs = 4'd3;
        end
      end
      if (c == of_c) ipu_OF = 1'b1;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    int c;
    logic [19:0] e;
    if (hs_rst_n && mon_on) begin
      c = gcyc - start_cyc;
      if (ipu_rf_ld_en) begin
        if (q_rf.size() == 0) chk("rf_ld_en_unexpected", ipu_rf_ld_en, 0);
        else begin
          e = q_rf.pop_front();
          chk("rf_ld_adrs", ipu_rf_ld_adrs, e[19:16]);
          chk("rf_load", ipu_rf_load, e[15:0]);
        end
      end
      if (ipu_im_ld_en) begin
        if (q_im.size() == 0) chk("im_ld_en_unexpected", ipu_im_ld_en, 0);
        else chk("im_instLoad", ipu_im_instLoad, q_im.pop_front());
      end
      if (ipu_rst) begin
        if (q_irst.size() == 0) chk("ipu_rst_unexpected", ipu_rst, 0);
        else chk("irst_cycle", c, q_irst.pop_front());
      end
      if (hs_done) begin
        if (q_dc.size() == 0) chk("done_unexpected", hs_done, 0);
        else begin
          chk("done_cycle", c, q_dc.pop_front());
          chk("done_ret_cnt", hs_ret_cnt, q_drc.pop_front());
          chk("done_of_flag", hs_of_flag, q_dof.pop_front());
          chk("done_busy", hs_busy, 0);
        end
      end
    end
  end

  task automatic wr(input bit sel, input int a, input logic [25:0] d);
    @(negedge clk);
    hs_wr_en = 1'b1; hs_wr_sel = sel; hs_wr_adrs = a[3:0]; hs_wr_data = d;
    @(negedge clk);
    hs_wr_en = 1'b0;
    if (sel) inst_m[a] = d; else row_m[a] = d[15:0];
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 16; i++) begin
      plan_rd[i] = 1'b0; plan_data[i] = '0; plan_adrs[i] = '0;
    end
    of_c = -1;
  endtask

  task automatic push_load(input int n);
    q_irst.push_back(0);
    for (int i = 0; i < 16; i++) q_rf.push_back({i[3:0], row_m[i]});
    for (int k = 0; k < n; k++) q_im.push_back(inst_m[k]);
  endtask

  task automatic push_done(input int c, input int rc, input int of);
    q_dc.push_back(c); q_drc.push_back(rc); q_dof.push_back(of);
  endtask

  task automatic run_start(input int n);
    n_run = n;
    @(negedge clk);
    hs_inst_cnt = 5'(n); hs_start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = gcyc; drv_on = 1'b1; mon_on = 1'b1; hs_start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int i;
    i = 0;
    while (done_pulses < target && i < 300) begin
      @(negedge clk); #2; i++;
    end
    chk("done_reached", done_pulses, target);
    drv_on = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd_chk(input int a, input bit ev, input logic [15:0] ed);
    hs_rd_adrs = a[3:0];
    #1;
    chk($sformatf("rd_vld[%0d]", a), hs_rd_vld, ev);
    if (ev) chk($sformatf("rd_data[%0d]", a), hs_rd_data, ed);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ipu_rst", ipu_rst, 1);
    chk("rst_busy", hs_busy, 0);
    chk("rst_done", hs_done, 0);
    chk("rst_rf_ld_en", ipu_rf_ld_en, 0);
    chk("rst_im_ld_en", ipu_im_ld_en, 0);
    chk("rst_ret_cnt", hs_ret_cnt, 0);
    chk("rst_of_flag", hs_of_flag, 0);
    @(negedge clk);
    hs_rst_n = 1'b1;
    #1;
    chk("ipu_rst_before_clk", ipu_rst, 1);
    @(negedge clk);
    chk("ipu_rst_after_clk", ipu_rst, 0);
    chk("idle_busy", hs_busy, 0);

    for (int i = 0; i < 16; i++) wr(1'b0, i, 26'(16'h0100 + i));

    // ---------------- T1: load sequence + WT_RD capture ----------------
    wr(1'b1, 0, {2'b11, 24'h000123});
    wr(1'b1, 1, {2'b00, 24'h0ABCDE});
    clear_plan();
    plan_rd[0] = 1'b1; plan_data[0] = 16'hBEEF; plan_adrs[0] = 4'd3;
    push_load(2);
    push_done(28, 1, 0);
    run_start(2);
    wait_done(1);
    rd_chk(3, 1'b1, 16'hBEEF);
    rd_chk(0, 1'b0, 16'h0000);
    chk("t1_ret_cnt_idle", hs_ret_cnt, 1);

    // ---------------- T2: zero instructions ----------------
    clear_plan();
    push_load(0);
    push_done(17, 0, 0);
    run_start(0);
    wait_done(2);
    rd_chk(3, 1'b0, 16'h0000);
    chk("t2_ret_cnt", hs_ret_cnt, 0);

    // ---------------- T3: overflow, run length, repeat address, robustness --
    wr(1'b1, 0, {2'b11, 24'h000001});
    wr(1'b1, 1, {2'b11, 24'h000002});
    wr(1'b1, 2, {2'b01, 24'h000003});
    wr(1'b1, 3, {2'b11, 24'h000004});
    clear_plan();
    plan_rd[0] = 1'b1; plan_data[0] = 16'h1111; plan_adrs[0] = 4'd1;
    plan_rd[1] = 1'b1; plan_data[1] = 16'h2222; plan_adrs[1] = 4'd1;
    plan_rd[3] = 1'b1; plan_data[3] = 16'h9999; plan_adrs[3] = 4'd9;
    of_c = 23;                               // run cycle 2 of a 4-instruction run
    push_load(4);
    push_done(32, 3, 1);                     // RUN is c=21..31: 11 cycles
    run_start(4);
    repeat (4) @(negedge clk);               // cycle 3: inside LD_RF
    hs_start = 1'b1; hs_wr_en = 1'b1; hs_wr_sel = 1'b0;
    hs_wr_adrs = 4'd2; hs_wr_data = 26'h000FFFF;
    @(negedge clk);
    hs_start = 1'b0; hs_wr_en = 1'b0;
    wait_done(3);
    rd_chk(1, 1'b1, 16'h2222);
    rd_chk(9, 1'b1, 16'h9999);
    rd_chk(3, 1'b0, 16'h0000);
    repeat (3) @(negedge clk);
    chk("t3_of_flag_idle", hs_of_flag, 1);

    // ---------------- T4: of_flag cleared by start, row 2 untouched ---------
    clear_plan();
    plan_rd[0] = 1'b1; plan_data[0] = 16'h4444; plan_adrs[0] = 4'd0;
    push_load(1);                            // row 2 still expects 0x0102
    push_done(26, 1, 0);
    run_start(1);
    wait_done(4);
    chk("t4_of_flag", hs_of_flag, 0);
    rd_chk(0, 1'b1, 16'h4444);
    rd_chk(1, 1'b0, 16'h0000);

    // ---------------- T5: reset during RUN ----------------
    clear_plan();
    plan_rd[0] = 1'b1; plan_data[0] = 16'h5555; plan_adrs[0] = 4'd5;
    push_load(2);
    run_start(2);
    repeat (22) @(negedge clk);              // cycle 21: RUN cycle 2
    #2;
    mon_on = 1'b0; drv_on = 1'b0;
    hs_rst_n = 1'b0;
    #1;
    chk("abort_ipu_rst", ipu_rst, 1);
    chk("abort_rf_ld_en", ipu_rf_ld_en, 0);
    chk("abort_im_ld_en", ipu_im_ld_en, 0);
    chk("abort_busy", hs_busy, 0);
    chk("abort_ret_cnt", hs_ret_cnt, 0);
    chk("abort_q_rf_left", q_rf.size(), 0);
    chk("abort_q_im_left", q_im.size(), 0);
    chk("abort_q_irst_left", q_irst.size(), 0);
    repeat (3) @(negedge clk);
    hs_rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ipu_rst_release", ipu_rst, 0);
    mon_on = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done", done_pulses, 4);
    chk("abort_idle_busy", hs_busy, 0);
    chk("q_done_left", q_dc.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ipu_host_seq.md
Name: ipu_host_seq

Overview:
Host-side sequencer for the IPU, acting as the initiator/collector at the other end of the IPU load and readback interface. It buffers register-file rows and instruction words supplied by a host write port. On start, it resets the IPU, streams the rows and instructions into the IPU load ports, and times the run. It then captures every WT_RD readback (row data plus address) into a result buffer, and latches a sticky overflow flag.

Parameters:
DATA_W, 16, register-file row width
INST_W, 26, instruction word width; opcode is IW[25:24], 2'b11 = WT_RD
ADR_W, 4, row address width (16 rows)
MAX_INST, 16, instruction buffer depth
RET_LAT, 7, cycles from first run cycle (cycle after last im_ld_en) to readback of instruction 0

Ports:
clk  in  1  system clock, rising edge
hs_rst_n  in  1  asynchronous active-low reset
hs_wr_en  in  1  host buffer write strobe (ignored while hs_busy)
hs_wr_sel  in  1  0 = row buffer, 1 = instruction buffer
hs_wr_adrs  in  4  buffer index
hs_wr_data  in  26  write data; rows use [15:0]
hs_inst_cnt  in  5  instructions to run, 0..16 (>16 clamps to 16), sampled on start
hs_start  in  1  single-cycle start pulse (ignored while hs_busy)
hs_rd_adrs  in  4  result buffer read index
hs_rd_data  out  16  result row at hs_rd_adrs (combinational read)
hs_rd_vld  out  1  result row at hs_rd_adrs was written this run
hs_busy  out  1  high from the cycle after start until DONE
hs_done  out  1  one-cycle pulse in DONE
hs_of_flag  out  1  sticky OR of ipu_OF during RUN
hs_ret_cnt  out  5  readbacks captured this run
ipu_rst  out  1  active-high reset to IPU
ipu_rf_ld_en  out  1  IPU register-file load enable
ipu_rf_load  out  16  IPU row data
ipu_rf_ld_adrs  out  4  IPU row address
ipu_im_ld_en  out  1  IPU instruction-load enable
ipu_im_instLoad  out  26  IPU instruction word
ipu_OF  in  1  IPU overflow
ipu_TB_ret  in  16  IPU readback row
ipu_ret_adrs  in  4  IPU readback address

Behaviour:
- Reset (async, hs_rst_n=0): state IDLE; ipu_rst=1; all other outputs 0; result-valid flags, counters, and of_flag cleared. Row/inst buffers are not cleared.
- Every IPU-facing output is registered.
- Host writes in IDLE: 1-cycle write into row[adrs] or inst[adrs]. Readable on ipu side only through a run.
- FSM: IDLE -> IRST -> LD_RF -> LD_IM -> RUN -> DONE -> IDLE.
- IDLE: ipu_rst=0 after the first clock out of reset. On hs_start, latch clamped inst_cnt, clear result-valid flags, hs_ret_cnt and hs_of_flag, then go to IRST.
- IRST: exactly 1 cycle with ipu_rst=1.
- LD_RF: 16 cycles. Cycle i drives ipu_rf_ld_en=1, ipu_rf_ld_adrs=i, ipu_rf_load=row[i], i=0..15 ascending.
- LD_IM: inst_cnt cycles. Cycle k drives ipu_im_ld_en=1, ipu_im_instLoad=inst[k]. If inst_cnt=0, skip LD_IM and RUN and go straight to DONE.
- RUN: lasts exactly RET_LAT+inst_cnt cycles, counted by a run counter starting at 0. All load enables are 0.
- Read tracking: a shift register of per-instruction is_read bits (inst[k][25:24]==2'b11). In run cycle RET_LAT+k, if inst k is WT_RD, capture result[ipu_ret_adrs] <= ipu_TB_ret, set its valid flag, and increment hs_ret_cnt.
- Input sampling: ipu_TB_ret/ipu_ret_adrs are sampled only in capture cycles. Z/X outside those cycles is never stored.
- Repeated address: a later readback to the same address overwrites the earlier one; hs_ret_cnt still counts both.
- Overflow: hs_of_flag |= ipu_OF on every RUN cycle. It holds after DONE until the next start.
- DONE: hs_done=1 for 1 cycle, hs_busy=0 in the same cycle, next state IDLE.
- hs_start asserted in DONE is ignored.
- hs_rd_data/hs_rd_vld are valid at any time, reflecting the buffer contents.
- Reset mid-run: FSM aborts immediately, ipu_rst=1, load enables drop to 0 asynchronously, no hs_done.

Test Plan:
- Reset: hold hs_rst_n=0, then release -> ipu_rst=1 during reset and 0 one cycle after; hs_busy=0, hs_ret_cnt=0, all ld_en=0.
- Load sequence: rows[i]=16'h0100+i, 2 instructions, start -> 1 IRST cycle; 16 rf_ld_en cycles with adrs 0..15 and data 0x0100..0x010F; 2 im_ld_en cycles carrying inst[0], inst[1].
- Readback capture: inst0=WT_RD, inst1=ADD; model drives ipu_TB_ret=16'hBEEF, ipu_ret_adrs=3 at run cycle 7 -> result[3]=0xBEEF, hs_rd_vld(3)=1, hs_ret_cnt=1. Z driven on other cycles is ignored.
- Zero instructions: inst_cnt=0, start -> no im_ld_en, no RUN; hs_done exactly 18 cycles after start (1 IRST + 16 LD_RF + 1 DONE).
- Overflow and run length: pulse ipu_OF in a single RUN cycle -> hs_of_flag=1 through DONE and into IDLE, cleared by the next start. With inst_cnt=4, RUN lasts 11 cycles.
- Robustness: hs_start and hs_wr_en during LD_RF are ignored (buffers unchanged). hs_rst_n=0 during RUN -> immediate abort, ipu_rst=1, no hs_done pulse.
